mem_rmw_ctrl: RTL and testbench

MEM-stage data-memory access controller that sits between the pipeline's memory request and the synchronous-read data memory, directly feeding and consuming the sub-word load/store unit. It latches one access, reads the aligned memory word and presents it to the load/store unit. For sub-word stores it then writes back the merged word from the load/store unit (read-modify-write). It stalls the pipeline through a ready handshake and flags misaligned accesses without touching memory.

---
 rtl/mem_rmw_ctrl.sv | 104 ++++++++++
 tb/tb_mem_rmw_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: MEM-stage data-memory controller with read-modify-write for sub-word stores
module mem_rmw_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [3:0]  in_access,
  input  logic [31:0] in_wdata,
  output logic [31:0] out_addr,
  output logic [3:0]  out_access,
  output logic [31:0] out_wdata,
  output logic [31:0] mem_word,
  input  logic [31:0] slu_wd,
  output logic        done,
  output logic        ale,
  output logic        dm_en,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  localparam logic [3:0] ST_W = 4'b1001, LD_W = 4'b0110, LD_BU = 4'b0001, LD_B = 4'b0010;
  localparam logic [3:0] ST_B = 4'b0011, LD_HU = 4'b0100, LD_H = 4'b1000, ST_H = 4'b1100;
  typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;
  state_t      state_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [3:0]  acc_q;
  logic        done_q, ale_q, en_q, we_q;
  logic        half, word, legal, mis, sub_st;
  assign half   = (in_access == LD_HU) || (in_access == LD_H) || (in_access == ST_H);
  assign word   = (in_access == ST_W) || (in_access == LD_W);
  assign legal  = half || word || (in_access == LD_BU) || (in_access == LD_B) || (in_access == ST_B);
  assign mis    = (half && in_addr[0]) || (word && (in_addr[1:0] != 2'b00));
  assign sub_st = (acc_q == ST_B) || (acc_q == ST_H);
  assign in_ready   = (state_q == IDLE);
  assign out_addr   = addr_q;
  assign out_access = acc_q;
  assign out_wdata  = wdata_q;
  assign mem_word   = word_q;
  assign done       = done_q;
  assign ale        = ale_q;
  assign dm_en      = en_q;
  assign dm_we      = we_q;
  assign dm_addr    = {addr_q[31:2], 2'b00};
  // sub-word stores write the merge the load/store unit builds from mem_word
  assign dm_wdata   = (state_q == WR) ? ((acc_q == ST_W) ? wdata_q : slu_wd) : '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      ale_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          addr_q  <= in_addr;
          acc_q   <= in_access;
          wdata_q <= in_wdata;
          if (!legal || mis) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ale_q   <= mis;
          end else if (in_access == ST_W) begin
            state_q <= WR;
            en_q    <= 1'b1;
            we_q    <= 1'b1;
          end else begin
            state_q <= RD;
            en_q    <= 1'b1;
          end
        end
        RD: begin
          state_q <= RDW;
          en_q    <= 1'b0;
        end
        RDW: begin
          word_q  <= dm_rdata;
          state_q <= sub_st ? WR : DONE;
          en_q    <= sub_st;
          we_q    <= sub_st;
          done_q  <= !sub_st;
        end
        WR: begin
          state_q <= DONE;
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ale_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// tb_mem_rmw_ctrl: directed bench with a synchronous memory and a sub-word merge model
module tb_mem_rmw_ctrl;
  logic        clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, in_ready;
  logic [31:0] in_addr = '0, in_wdata = '0, out_addr, out_wdata, mem_word, slu_wd;
  logic [3:0]  in_access = '0, out_access;
  logic        done, ale, dm_en, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = '0;
  logic [31:0] mem [0:4095];
  int          compared = 0, mismatched = 0;

  mem_rmw_ctrl dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_access(in_access), .in_wdata(in_wdata),
    .out_addr(out_addr), .out_access(out_access), .out_wdata(out_wdata),
    .mem_word(mem_word), .slu_wd(slu_wd), .done(done), .ale(ale),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (dm_en) begin
      if (dm_we) mem[dm_addr[13:2]] <= dm_wdata;
      else dm_rdata <= mem[dm_addr[13:2]];
    end

  always_comb begin
    slu_wd = mem_word;
    if (out_access == 4'b0011) slu_wd[8*out_addr[1:0] +: 8] = out_wdata[7:0];
    if (out_access == 4'b1100) slu_wd[16*out_addr[1] +: 16] = out_wdata[15:0];
  end

  function automatic logic [31:0] ld_b(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    b = w[8*lane +: 8];
    return {{24{b[7]}}, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] acc, input logic [31:0] wd);
    in_addr = a; in_access = acc; in_wdata = wd; in_valid = 1'b1;
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h400] = 32'h88442211;
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_done", {30'd0, done, ale}, 32'd0);
    chk("rst_en_we", {30'd0, dm_en, dm_we}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_word", mem_word, 32'd0);
    chk("rst_outs", out_addr | out_wdata | {28'd0, out_access}, 32'd0);
    rstn = 1'b1;
    cyc();
    // ld_b 0x1001
    req(32'h1001, 4'b0010, 32'h0);
    chk("ldb_c1_en_we", {30'd0, dm_en, dm_we}, 32'b10);
    chk("ldb_c1_addr", dm_addr, 32'h1000);
    chk("ldb_c1_busy", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("ldb_c2", {29'd0, dm_en, dm_we, done}, 32'd0);
    cyc();
    chk("ldb_c3_done", {30'd0, done, ale}, 32'b10);
    chk("ldb_word", mem_word, 32'h88442211);
    chk("ldb_out_addr", out_addr, 32'h1001);
    chk("ldb_result", ld_b(mem_word, out_addr[1:0]), 32'h00000022);
    cyc();
    chk("ldb_c4", {30'd0, done, in_ready}, 32'b01);
    // st_b 0x1002
    req(32'h1002, 4'b0011, 32'h000000AB);
    chk("stb_c1_en_we", {30'd0, dm_en, dm_we}, 32'b10);
    cyc();
    chk("stb_c2_en", {31'd0, dm_en}, 32'd0);
    cyc();
    chk("stb_c3_en_we", {29'd0, dm_en, dm_we, done}, 32'b110);
    chk("stb_c3_wdata", dm_wdata, 32'h88AB2211);
    chk("stb_c3_addr", dm_addr, 32'h1000);
    cyc();
    chk("stb_c4_done", {30'd0, done, ale}, 32'b10);
    chk("stb_mem", mem[12'h400], 32'h88AB2211);
    chk("stb_c4_wdata", dm_wdata, 32'd0);
    cyc();
    // st_w 0x1000, then read back
    req(32'h1000, 4'b1001, 32'hDEADBEEF);
    chk("stw_c1_en_we", {29'd0, dm_en, dm_we, done}, 32'b110);
    chk("stw_c1_wdata", dm_wdata, 32'hDEADBEEF);
    cyc();
    chk("stw_c2_done", {29'd0, dm_en, done, ale}, 32'b010);
    chk("stw_mem", mem[12'h400], 32'hDEADBEEF);
    cyc();
    req(32'h1000, 4'b0110, 32'h0);
    cyc(); cyc();
    chk("ldw_done", {31'd0, done}, 32'd1);
    chk("ldw_word", mem_word, 32'hDEADBEEF);
    cyc();
    req(32'h1000, 4'b1001, 32'h88442211);
    cyc(); cyc();
    // misaligned and illegal
    req(32'h1001, 4'b1000, 32'h0);
    chk("ldh_mis", {29'd0, dm_en, done, ale}, 32'b011);
    cyc();
    chk("ldh_after", {28'd0, dm_en, done, ale, in_ready}, 32'b0001);
    req(32'h1002, 4'b0110, 32'h0);
    chk("ldw_mis", {29'd0, dm_en, done, ale}, 32'b011);
    cyc();
    req(32'h1000, 4'b0000, 32'h0);
    chk("illegal", {29'd0, dm_en, done, ale}, 32'b010);
    cyc();
    // st_h aborted by reset in WR
    req(32'h1000, 4'b1100, 32'h00005555);
    cyc(); cyc();
    chk("sth_wr", {30'd0, dm_en, dm_we}, 32'b11);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_en_we", {30'd0, dm_en, dm_we}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    #1 rstn = 1'b1;
    cyc();
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_mem", mem[12'h400], 32'h88442211);
    cyc();
    chk("abort_no_done2", {31'd0, done}, 32'd0);
    // back-to-back ld_w with in_valid held
    in_addr = 32'h1000; in_access = 4'b0110; in_valid = 1'b1;
    cyc();
    chk("b2b_c1", {30'd0, in_ready, dm_en}, 32'b01);
    cyc(); cyc();
    chk("b2b_c3_done", {30'd0, done, in_ready}, 32'b10);
    cyc();
    chk("b2b_c4_accept", {30'd0, done, in_ready}, 32'b01);
    cyc();
    chk("b2b_c5_read", {30'd0, in_ready, dm_en}, 32'b01);
    cyc();
    chk("b2b_c6", {31'd0, done}, 32'd0);
    cyc();
    chk("b2b_c7_done", {30'd0, done, ale}, 32'b10);
    chk("b2b_word", mem_word, 32'h88442211);
    in_valid = 1'b0;
    cyc();
    chk("b2b_idle", {30'd0, done, in_ready}, 32'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
